ps2_tx: RTL and testbench
=========================

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, system clock frequency in Hz.
REQ-002 SHALL have parameter INHIBIT, default 2500, number of clock cycles the host holds PS/2 clock low before the start bit (100 us at 25 MHz).
REQ-003 SHALL have parameter TIMEOUT, default 375000, maximum number of clock cycles to wait for any single device event (15 ms).
REQ-004 SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ps_clk, input, 1 bit: PS/2 clock line as read from the pad.
REQ-007 SHALL have port ps_dat, input, 1 bit: PS/2 data line as read from the pad.
REQ-008 SHALL have port ps_clk_oe, output, 1 bit: 1 drives the clock pad low; 0 releases it to Z.
REQ-009 SHALL have port ps_dat_oe, output, 1 bit: 1 drives the data pad low; 0 releases it to Z.
REQ-010 SHALL have port data, input, 8 bits: the command byte; it is sampled when start is accepted.
REQ-011 SHALL have port start, input, 1 bit: single-cycle request to send data.
REQ-012 SHALL have port busy, output, 1 bit: high from the accepted start until done; the keyboard receiver ignores the line while busy is high.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a transfer.
REQ-014 SHALL have port err, output, 1 bit: valid in the done cycle; 1 means no ACK was received or a timeout occurred.

Function
REQ-015 SHALL pass ps_clk and ps_dat through 2-flop synchronizers, then a third register; a falling edge is detected when the previous synchronized value is 1 and the current one is 0.
REQ-016 SHALL implement these states: IDLE, INHIBIT, START, BITS, ACK, WAITIDLE.
REQ-017 IDLE: both oe outputs are 0 and busy is 0; start=1 latches data, computes the odd parity bit (~^data), loads the counter with INHIBIT-1, and goes to INHIBIT.
REQ-018 INHIBIT: ps_clk_oe=1 and ps_dat_oe=0; when the counter reaches 0, go to START.
REQ-019 START: for exactly 1 cycle, ps_clk_oe=1 and ps_dat_oe=1; then release the clock (ps_clk_oe=0), hold data low, clear the bit index to 0, and go to BITS.
REQ-020 BITS: on each ps_clk falling edge, drive frame bit n and increment n. The frame is bits 0..7 of data (LSB first), then parity, then stop (1). Driving bit value b means ps_dat_oe=~b.
REQ-021 BITS: after the stop bit is placed, i.e. the 10th falling edge (ps_dat_oe=0), go to ACK.
REQ-022 ACK: on the next falling edge, sample the synchronized ps_dat; 0 means ACK ok, 1 sets the error flag; then go to WAITIDLE.
REQ-023 WAITIDLE: when synchronized ps_clk=1 and ps_dat=1, pulse done, present err, and return to IDLE.
REQ-024 SHALL apply a timeout: in BITS, ACK and WAITIDLE, the counter reloads with TIMEOUT-1 on entry and on every falling edge. If it reaches 0, release both lines, pulse done with err=1, and return to IDLE.
REQ-025 SHALL ignore start when busy=1; any start not in IDLE has no effect.
REQ-026 SHALL assert busy=1 in every state except IDLE, including the done cycle's state; busy SHALL fall in the cycle after done.
REQ-027 SHALL size the counter to $clog2(max(INHIBIT,TIMEOUT)+1) bits, with no wrap: it holds at 0.
REQ-028 ps_dat_oe and ps_clk_oe SHALL never be 1 outside INHIBIT, START, BITS and ACK. In ACK, ps_dat_oe is 0 (the device drives the line).

Reset
REQ-029 With reset=1 at a clock edge: state=IDLE, ps_clk_oe=0, ps_dat_oe=0, busy=0, done=0, err=0, counter=0, bit index=0.
REQ-030 Reset SHALL override start in the same cycle.
REQ-031 Reset mid-transfer SHALL release both lines at that edge, and no done pulse SHALL follow.

Verification (INHIBIT=8, TIMEOUT=200 in bench; device model clocks at a 40-cycle period)
REQ-032 start with data=8'hED, device ACKs -> clock low for 8 cycles; frame 0,1,0,1,1,0,1,1,1,1 (start, data LSB-first, parity=1) followed by stop=1; done with err=0.
REQ-033 start with data=8'hF4 -> data bits 0,0,1,0,1,1,1,1, parity=0, done with err=0.
REQ-034 Device does not pull data low on the 11th clock -> done with err=1; lines released.
REQ-035 Device stops clocking after the 4th falling edge -> 200 cycles later, done with err=1, both oe=0, busy falls in the next cycle.
REQ-036 start pulsed again while busy, then reset asserted during BITS -> the second start is ignored; after reset, oe=0, busy=0, no done; a new start with 8'h01 sends parity=0 correctly.

Source files
------------

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send,
// shifts a command byte out on device clocks and checks the device ACK.
module ps2_tx #(
  parameter int CLK_HZ  = 25000000,
  parameter int INHIBIT = 2500,
  parameter int TIMEOUT = 375000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps_clk,
  input  logic       ps_dat,
  output logic       ps_clk_oe,
  output logic       ps_dat_oe,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CMAX = (INHIBIT > TIMEOUT) ? INHIBIT : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] INH_LD = CW'(INHIBIT - 1);
  localparam logic [CW-1:0] TO_LD  = CW'(TIMEOUT - 1);

  if (CLK_HZ <= 0) begin : g_bad_clk_hz
    $error("ps2_tx: CLK_HZ must be positive");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_BITS,
    ST_ACK,
    ST_WAITIDLE
  } state_t;

  state_t        state;
  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [9:0]    frame;
  logic [3:0]    idx;
  logic [CW-1:0] cnt;
  logic          err_flag;

  logic          clk_s;
  logic          dat_s;
  logic          fall;
  logic          cnt_zero;
  logic [CW-1:0] cnt_dec;
  logic          timed;
  logic          line_idle;

  assign clk_s     = clk_sync[1];
  assign dat_s     = dat_sync[1];
  assign fall      = clk_sync[2] & ~clk_sync[1];
  assign cnt_zero  = (cnt == '0);
  assign cnt_dec   = cnt_zero ? cnt : cnt - CW'(1);
  assign line_idle = clk_s & dat_s;
  assign timed     = (state == ST_BITS) || (state == ST_ACK) ||
                     (state == ST_WAITIDLE);

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[1:0], ps_clk};
      dat_sync <= {dat_sync[0], ps_dat};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      ps_clk_oe <= 1'b0;
      ps_dat_oe <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_flag  <= 1'b0;
      frame     <= '0;
      idx       <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          ps_clk_oe <= 1'b0;
          ps_dat_oe <= 1'b0;
          busy      <= 1'b0;
          if (start && !busy) begin
            frame     <= {1'b1, ~^data, data};
            cnt       <= INH_LD;
            err_flag  <= 1'b0;
            busy      <= 1'b1;
            ps_clk_oe <= 1'b1;
            state     <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (cnt_zero) begin
            ps_dat_oe <= 1'b1;
            state     <= ST_START;
          end else begin
            cnt <= cnt_dec;
          end
        end
        ST_START: begin
          ps_clk_oe <= 1'b0;
          idx       <= '0;
          cnt       <= TO_LD;
          state     <= ST_BITS;
        end
        ST_BITS: begin
          if (fall) begin
            ps_dat_oe <= ~frame[idx];
            idx       <= idx + 4'd1;
            cnt       <= TO_LD;
            if (idx == 4'd9)
              state <= ST_ACK;
          end else begin
            cnt <= cnt_dec;
          end
        end
        ST_ACK: begin
          if (fall) begin
            err_flag <= dat_s;
            cnt      <= TO_LD;
            state    <= ST_WAITIDLE;
          end else begin
            cnt <= cnt_dec;
          end
        end
        ST_WAITIDLE: begin
          if (line_idle) begin
            done  <= 1'b1;
            err   <= err_flag;
            state <= ST_IDLE;
          end else if (fall) begin
            cnt <= TO_LD;
          end else begin
            cnt <= cnt_dec;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A stalled device: abandon the transfer with an error.
      if (timed && cnt_zero && !fall &&
          !(state == ST_WAITIDLE && line_idle)) begin
        ps_clk_oe <= 1'b0;
        ps_dat_oe <= 1'b0;
        done      <= 1'b1;
        err       <= 1'b1;
        state     <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Randomized bench for ps2_tx with an open-drain PS/2 device model.
module tb_ps2_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps_clk;
  logic       ps_dat;
  logic       ps_clk_oe;
  logic       ps_dat_oe;
  logic [7:0] data = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic       err;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  assign ps_clk = dev_clk & ~ps_clk_oe;
  assign ps_dat = dev_dat & ~ps_dat_oe;

  ps2_tx #(
    .INHIBIT(8),
    .TIMEOUT(200)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ps_clk   (ps_clk),
    .ps_dat   (ps_dat),
    .ps_clk_oe(ps_clk_oe),
    .ps_dat_oe(ps_dat_oe),
    .data     (data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int inh_cnt = 0;
  int fall4_cyc = 0;
  bit last_err = 1'b0;
  bit prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        last_err = err;
        done_cyc = cyc;
        check("busy_in_done", busy, 1);
      end
      if (prev_done)
        check("busy_after_done", busy, 0);
      if (!busy)
        check("idle_lines", {ps_clk_oe, ps_dat_oe}, 0);
      if (busy && ps_clk_oe && !ps_dat_oe)
        inh_cnt++;
    end
    prev_done = done;
  end

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clock);
    data  = d;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Device: 40-cycle clock, samples on rising edges, optional ACK.
  task automatic dev_run(input bit ack, input int nfall,
                         output logic [10:0] bits);
    bit ok;
    ok = 1'b0;
    bits = '0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      ok = busy && !ps_clk_oe && ps_dat_oe;
    end
    check("req_to_send", ok, 1);
    if (!ok) return;
    bits[0] = ps_dat;
    repeat (20) @(negedge clock);
    for (int k = 1; k <= nfall; k++) begin
      dev_clk = 1'b0;
      if (k == 4) fall4_cyc = cyc;
      repeat (20) @(negedge clock);
      dev_clk = 1'b1;
      if (k <= 10) bits[k] = ps_dat;
      if (k == 10 && ack) begin
        repeat (10) @(negedge clock);
        dev_dat = 1'b0;
        repeat (10) @(negedge clock);
      end else begin
        repeat (20) @(negedge clock);
      end
    end
    dev_dat = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] d, input bit ack,
                      input int nfall, input bit exp_err);
    logic [10:0] bits, exp_bits, mask;
    int dsnap, isnap, ones, lat;
    bit par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = (ones % 2 == 0);
    exp_bits = {1'b1, par, d, 1'b0};
    mask = 11'((1 << (nfall + 1)) - 1);
    dsnap = done_cnt;
    isnap = inh_cnt;
    pulse_start(d);
    dev_run(ack, nfall, bits);
    for (int i = 0; i < 600 && done_cnt == dsnap; i++)
      @(negedge clock);
    check("done_count", done_cnt - dsnap, 1);
    check("done_err", last_err, exp_err);
    check("inhibit_len", inh_cnt - isnap, 8);
    if (nfall >= 10) begin
      check("frame", bits, exp_bits);
      check("parity", bits[9], par);
    end else begin
      check("frame_head", bits & mask, exp_bits & mask);
      lat = done_cyc - fall4_cyc;
      check("timeout_lat", (lat >= 200 && lat <= 204), 1);
    end
    repeat (2) @(negedge clock);
    check("released", {ps_clk_oe, ps_dat_oe, busy}, 0);
  endtask

  initial begin
    logic [10:0] bits;
    int dsnap, isnap;

    @(negedge clock);
    start = 1'b1;
    data  = 8'h55;
    @(negedge clock);
    check("reset_state", {ps_clk_oe, ps_dat_oe, busy, done, err}, 0);
    start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_no_start", busy, 0);

    xfer(8'hED, 1'b1, 11, 1'b0);
    xfer(8'hF4, 1'b1, 11, 1'b0);
    for (int i = 0; i < 4; i++)
      xfer(8'($urandom_range(0, 255)), 1'b1, 11, 1'b0);
    xfer(8'($urandom_range(0, 255)), 1'b0, 11, 1'b1);
    xfer(8'($urandom_range(0, 255)), 1'b1, 4, 1'b1);

    dsnap = done_cnt;
    isnap = inh_cnt;
    pulse_start(8'hA5);
    repeat (2) @(negedge clock);
    check("busy_2nd", busy, 1);
    pulse_start(8'h5A);
    dev_run(1'b1, 3, bits);
    check("inhibit_2nd", inh_cnt - isnap, 8);
    check("head_2nd", bits & 11'h00F, 11'h00A);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_mid", {ps_clk_oe, ps_dat_oe, busy, done}, 0);
    reset = 1'b0;
    repeat (300) @(negedge clock);
    check("no_done_after_reset", done_cnt - dsnap, 0);
    check("idle_after_reset", {ps_clk_oe, ps_dat_oe, busy}, 0);

    xfer(8'h01, 1'b1, 11, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
